// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three buses around the data-memory arbiter:
//   cpu_*  : core load/store path (cpu_req/we/addr/wdata in, cpu_rdata/stall out)
//   host_* : host request channel (valid/we/lock/addr/wdata in,
//            ready/rvalid/rdata out)
//   mem_*  : single memory port (addr/wdata/we/re out, rdata in)
//   grant_host : status, host owns the port this cycle
// The arbiter connects through the slave modport; the requesters and the
// memory side connect through the master modport.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              host_valid;
    logic              host_we;
    logic              host_lock;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ready;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    logic              grant_host;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_valid, host_we, host_lock, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata,
        output grant_host
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_valid, host_we, host_lock, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata,
        input  grant_host
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported data memory between the single-cycle core and a
// host port. At most one requester is granted per cycle; the loser waits.
// Round-robin arbitration, except that a host holding host_lock keeps the
// port for up to HOST_MAX_BURST consecutive grants.
//
// Ports
//   clk              : rising-edge clock
//   reset            : asynchronous, active-low
//   bus              : cpu/host/memory buses (mem_port_arbiter_if.slave)
//   o_dbg_last_grant : 1 = host was the last grantee, 0 = CPU
//   o_dbg_burst_cnt  : consecutive host grants counter
//
// Host handshake: a request transfers on a rising edge where host_valid and
// host_ready are both 1. The host holds host_valid and its payload stable
// until host_ready; host_ready is never 1 without host_valid. A read returns
// host_rvalid/host_rdata exactly one cycle after its transfer. The CPU side
// has no ready: cpu_stall=1 tells the core to re-present the same access.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int HOST_MAX_BURST = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    mem_port_arbiter_if.slave                    bus,
    output logic                                 o_dbg_last_grant,
    output logic [$clog2(HOST_MAX_BURST+1)-1:0]  o_dbg_burst_cnt
);
    localparam int CNT_W = $clog2(HOST_MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(HOST_MAX_BURST);

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_HOST = 1'b1
    } grant_t;

    grant_t            r_last_grant;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_lock_q;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_cpu_gnt;
    logic              w_host_gnt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [DATA_W-1:0] w_cpu_rdata;

    // Grant decision. Gating with reset forces every grant-derived output
    // (mem_we/re, host_ready, grant_host, cpu_stall) low while in reset.
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_host_gnt = 1'b0;
        if (reset) begin
            if (bus.cpu_req && bus.host_valid) begin
                if (r_lock_q && (r_burst_cnt < MAX_C)) begin
                    w_host_gnt = 1'b1;
                end else if (r_last_grant == GNT_HOST) begin
                    w_cpu_gnt = 1'b1;
                end else begin
                    w_host_gnt = 1'b1;
                end
            end else if (bus.cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (bus.host_valid) begin
                w_host_gnt = 1'b1;
            end
        end
    end

    // Memory port mux; an ungranted cycle leaves the port fully quiet.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_cpu_rdata = '0;
        if (w_cpu_gnt) begin
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
            w_mem_we    = bus.cpu_we;
            w_mem_re    = ~bus.cpu_we;
            w_cpu_rdata = bus.mem_rdata;
        end else if (w_host_gnt) begin
            w_mem_addr  = bus.host_addr;
            w_mem_wdata = bus.host_wdata;
            w_mem_we    = bus.host_we;
            w_mem_re    = ~bus.host_we;
        end
    end

    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_re      = w_mem_re;
    assign bus.cpu_rdata   = w_cpu_rdata;
    assign bus.cpu_stall   = bus.cpu_req & ~w_cpu_gnt & reset;
    assign bus.host_ready  = w_host_gnt;
    assign bus.grant_host  = w_host_gnt;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.host_rdata  = r_host_rdata;

    assign o_dbg_last_grant = (r_last_grant == GNT_HOST);
    assign o_dbg_burst_cnt  = r_burst_cnt;

    // Reset leaves last_grant = HOST so the CPU wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant  <= GNT_HOST;
            r_burst_cnt   <= '0;
            r_lock_q      <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else if (w_host_gnt) begin
            r_last_grant  <= GNT_HOST;
            r_lock_q      <= bus.host_lock;
            if (r_burst_cnt != MAX_C) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
            r_host_rvalid <= ~bus.host_we;
            if (!bus.host_we) begin
                r_host_rdata <= bus.mem_rdata;
            end
        end else if (w_cpu_gnt) begin
            r_last_grant  <= GNT_CPU;
            r_burst_cnt   <= '0;
            r_lock_q      <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_burst_cnt   <= '0;
            r_host_rvalid <= 1'b0;
        end
    end
endmodule
